shift_sequencer: RTL and testbench

- Multi-cycle shift unit controller for the MIPS datapath.
- Owns a WIDTH-bit shift register and sequences SLL/SRL/SRA/ROR one bit per clock for shamt cycles.
- Handshake: start, then busy/done. Drives a stall request to the pipeline while an operation is in flight.
- Sits beside the ALU; the instruction decoder issues start with op/shamt.

---
 rtl/shift_sequencer.sv | 118 +++++++++++
 tb/tb_shift_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Purpose : multi-cycle SLL/SRL/SRA/ROR unit beside the ALU, one bit position per clock.
// Latency : start accepted at edge k -> done high in the cycle after edge k+shamt (shamt==0: next cycle).
// Backpress: start is ignored (not queued) while busy; stall holds the pipeline for the whole operation.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   start, op, shamt, dataIn   request, operation (00 SLL, 01 SRL, 10 SRA, 11 ROR), amount, operand
//   dataOut           result register, updated only on entry to DONE
//   busy, done        registered status: in SHIFT / one-cycle result-valid pulse
//   stall             combinational pipeline hold request
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   dataIn,
  output logic [WIDTH-1:0]   dataOut,
  output logic               busy,
  output logic               done,
  output logic               stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t             state;
  state_t             nextState;
  logic [WIDTH-1:0]   shiftReg;
  logic [WIDTH-1:0]   shifted;
  logic [1:0]         opReg;
  logic [SHAMT_W-1:0] count;
  logic               accept;
  logic               lastStep;

  // A new request is taken in IDLE and also in DONE, which allows back-to-back issue.
  assign accept   = start && (state != SHIFT);
  assign lastStep = (count == SHAMT_W'(1));

  // One-bit step of the captured operand according to the captured op.
  always_comb begin
    shifted = shiftReg;
    case (opReg)
      OP_SLL:  shifted = {shiftReg[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, shiftReg[WIDTH-1:1]};
      OP_SRA:  shifted = {shiftReg[WIDTH-1], shiftReg[WIDTH-1:1]};
      default: shifted = {shiftReg[0], shiftReg[WIDTH-1:1]};
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      SHIFT:   nextState = lastStep ? DONE : SHIFT;
      default: begin
        if (accept) begin
          nextState = (shamt != '0) ? SHIFT : DONE;
        end else begin
          nextState = IDLE;
        end
      end
    endcase
  end

  // Outputs: both derive from the state register, so they are registered.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: operand capture, stepping and result load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shiftReg <= '0;
      opReg    <= '0;
      count    <= '0;
      dataOut  <= '0;
    end else if (accept) begin
      shiftReg <= dataIn;
      opReg    <= op;
      count    <= shamt;
      if (shamt == '0) begin
        dataOut <= dataIn;
      end
    end else if (state == SHIFT) begin
      shiftReg <= shifted;
      count    <= count - SHAMT_W'(1);
      if (lastStep) begin
        dataOut <= shifted;
      end
    end
  end

  // Stall is raised in the same cycle as an accepted non-zero request so the
  // pipeline never advances past the issuing instruction.
  assign stall = busy || (start && (shamt != '0) && (state != SHIFT));

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic        stall;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .op     (op),
    .shamt  (shamt),
    .dataIn (dataIn),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic [31:0] expRes;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge, then sample every negedge until done.
  task automatic runOp(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                       output int busyCnt, output bit gotDone, output logic [31:0] res,
                       output bit stallOk);
    @(negedge CLK);
    start = 1'b1; op = o; shamt = s; dataIn = d;
    #1;
    chk("stall_on_issue", {31'b0, stall}, {31'b0, (s != 5'd0)});
    @(negedge CLK);
    start = 1'b0;
    busyCnt = 0; gotDone = 1'b0; res = '0; stallOk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        gotDone = 1'b1;
        res = dataOut;
        if (stall) stallOk = 1'b0;
        break;
      end
      if (busy) busyCnt++;
      if (stall !== busy) stallOk = 1'b0;
      @(negedge CLK);
    end
  endtask

  vec_t vecs[7];
  int          busyCnt;
  bit          gotDone;
  bit          stallOk;
  logic [31:0] res;
  logic [31:0] lastRes;

  initial begin
    vecs[0] = '{2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010};
    vecs[1] = '{2'b10, 5'd8,  32'h8000_FFFF, 32'hFF80_00FF};
    vecs[2] = '{2'b01, 5'd31, 32'hFFFF_0000, 32'h0000_0001};
    vecs[3] = '{2'b11, 5'd4,  32'h0000_00FF, 32'hF000_000F};
    vecs[4] = '{2'b00, 5'd0,  32'h0000_FFFF, 32'h0000_FFFF};
    vecs[5] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};
    vecs[6] = '{2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002};

    // Reset, with start asserted to show reset wins.
    RST = 1'b1; start = 1'b1; op = 2'b00; shamt = 5'd3; dataIn = 32'hDEAD_BEEF;
    repeat (3) @(negedge CLK);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dataOut", dataOut, 32'd0);
    start = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("idle_dataOut", dataOut, 32'd0);

    // Table-driven operations.
    for (int v = 0; v < 7; v++) begin
      runOp(vecs[v].op, vecs[v].shamt, vecs[v].data, busyCnt, gotDone, res, stallOk);
      chk($sformatf("v%0d_done", v), {31'b0, gotDone}, 32'd1);
      chk($sformatf("v%0d_busyCycles", v), busyCnt, {27'b0, vecs[v].shamt});
      chk($sformatf("v%0d_result", v), res, vecs[v].expRes);
      chk($sformatf("v%0d_stallTracksBusy", v), {31'b0, stallOk}, 32'd1);
      @(negedge CLK);
      chk($sformatf("v%0d_donePulse", v), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_hold", v), dataOut, vecs[v].expRes);
    end
    lastRes = vecs[6].expRes;

    // Start during SHIFT is ignored; dataOut holds the previous result meanwhile.
    @(negedge CLK);
    start = 1'b1; op = 2'b00; shamt = 5'd10; dataIn = 32'h1;
    @(negedge CLK);
    start = 1'b0;
    busyCnt = 0; gotDone = 1'b0; res = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin gotDone = 1'b1; res = dataOut; break; end
      if (busy) busyCnt++;
      if (busyCnt == 3 && start == 1'b0 && i == 2) begin
        chk("ign_holdDuringShift", dataOut, lastRes);
        start = 1'b1; op = 2'b01; shamt = 5'd2; dataIn = 32'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
    end
    chk("ign_done", {31'b0, gotDone}, 32'd1);
    chk("ign_busyCycles", busyCnt, 32'd10);
    chk("ign_result", res, 32'h0000_0400);

    // Mid-operation reset aborts with no done pulse.
    @(negedge CLK);
    start = 1'b1; op = 2'b00; shamt = 5'd10; dataIn = 32'h1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_busyBefore", {31'b0, busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_dataOut", dataOut, 32'd0);
    gotDone = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (done) gotDone = 1'b1;
    end
    chk("abort_noLateDone", {31'b0, gotDone}, 32'd0);
    runOp(2'b01, 5'd4, 32'h0000_00FF, busyCnt, gotDone, res, stallOk);
    chk("postRst_done", {31'b0, gotDone}, 32'd1);
    chk("postRst_busyCycles", busyCnt, 32'd4);
    chk("postRst_result", res, 32'h0000_000F);

    // Back-to-back: start held across the DONE cycle.
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b1; op = 2'b00; shamt = 5'd1; dataIn = 32'h1;
    @(negedge CLK);
    chk("b2b_busy1", {31'b0, busy}, 32'd1);
    shamt = 5'd2; dataIn = 32'h3;
    @(negedge CLK);
    chk("b2b_done1", {31'b0, done}, 32'd1);
    chk("b2b_res1", dataOut, 32'h0000_0002);
    @(negedge CLK);
    start = 1'b0;
    chk("b2b_busy2", {31'b0, busy}, 32'd1);
    chk("b2b_noDone", {31'b0, done}, 32'd0);
    @(negedge CLK);
    chk("b2b_busy2b", {31'b0, busy}, 32'd1);
    chk("b2b_holdRes1", dataOut, 32'h0000_0002);
    @(negedge CLK);
    chk("b2b_done2", {31'b0, done}, 32'd1);
    chk("b2b_res2", dataOut, 32'h0000_000C);
    @(negedge CLK);
    chk("b2b_idle", {31'b0, done | busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
